// File: rtl/calendar_counter.sv
// Day/month/year calendar with Gregorian leap rule, registered day-of-week,
// per-field set-mode editing and validated bulk load.
module calendar_counter #(
  parameter int YEAR_BASE = 2000,
  parameter int YEAR_MAX  = 99,
  parameter int DAY_W     = 5,
  parameter int MON_W     = 4,
  parameter int YEAR_W    = 7
) (
  input  logic              clk_1Hz,
  input  logic              rst,
  input  logic              day_tick,
  input  logic [1:0]        mode,
  input  logic              set_inc,
  input  logic              set_dec,
  input  logic              load,
  input  logic [DAY_W-1:0]  load_day,
  input  logic [MON_W-1:0]  load_mon,
  input  logic [YEAR_W-1:0] load_year,
  output logic [DAY_W-1:0]  days,
  output logic [MON_W-1:0]  months,
  output logic [YEAR_W-1:0] years,
  output logic [2:0]        dow,
  output logic              leap,
  output logic              year_wrap,
  output logic              load_err
);

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_DAY  = 2'd1,
    MODE_SET_MON  = 2'd2,
    MODE_SET_YEAR = 2'd3
  } mode_e;

  function automatic logic is_leap_year(input logic [YEAR_W-1:0] yoff);
    int y;
    y = YEAR_BASE + int'(yoff);
    return (((y % 4) == 0) && ((y % 100) != 0)) || ((y % 400) == 0);
  endfunction

  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] m, input logic lp);
    int n;
    case (int'(m))
      2:             n = lp ? 29 : 28;
      4, 6, 9, 11:   n = 30;
      default:       n = 31;
    endcase
    return DAY_W'(n);
  endfunction

  // Sakamoto: Jan/Feb are treated as months of the previous year.
  function automatic logic [2:0] sakamoto(input logic [DAY_W-1:0] d, input logic [MON_W-1:0] m,
                                          input logic [YEAR_W-1:0] yoff);
    int y;
    int t;
    int s;
    y = YEAR_BASE + int'(yoff);
    if (int'(m) < 3) y = y - 1;
    case (int'(m))
      1: t = 0;   2: t = 3;   3: t = 2;   4: t = 5;
      5: t = 0;   6: t = 3;   7: t = 5;   8: t = 1;
      9: t = 4;  10: t = 6;  11: t = 2;  12: t = 4;
      default: t = 0;
    endcase
    s = y + y / 4 - y / 100 + y / 400 + t + int'(d);
    return 3'(s % 7);
  endfunction

  localparam logic [DAY_W-1:0]  DAY_ONE   = DAY_W'(1);
  localparam logic [MON_W-1:0]  MON_ONE   = MON_W'(1);
  localparam logic [MON_W-1:0]  MON_TOP   = MON_W'(12);
  localparam logic [YEAR_W-1:0] YEAR_ONE  = YEAR_W'(1);
  localparam logic [YEAR_W-1:0] YEAR_TOP  = YEAR_W'(YEAR_MAX);
  localparam logic [2:0]        DOW_RESET = sakamoto(DAY_W'(1), MON_W'(1), YEAR_W'(0));

  logic [DAY_W-1:0]  days_q, days_d;
  logic [MON_W-1:0]  months_q, months_d;
  logic [YEAR_W-1:0] years_q, years_d;
  logic [2:0]        dow_q;
  logic              year_wrap_q, year_wrap_d;
  logic              load_err_q, load_err_d;

  mode_e             mode_sel;
  logic              leap_cur;
  logic [DAY_W-1:0]  dim_cur;
  logic [MON_W-1:0]  mon_edit;
  logic [YEAR_W-1:0] year_edit;
  logic [DAY_W-1:0]  dim_mon_edit;
  logic [DAY_W-1:0]  dim_year_edit;
  logic              load_ok;

  assign mode_sel = mode_e'(mode);
  assign leap_cur = is_leap_year(years_q);
  assign dim_cur  = days_in_month(months_q, leap_cur);

  // Candidate edited fields; set_inc selects direction when exactly one pulse is high.
  assign mon_edit  = set_inc ? ((months_q == MON_TOP) ? MON_ONE : months_q + MON_ONE)
                             : ((months_q == MON_ONE) ? MON_TOP : months_q - MON_ONE);
  assign year_edit = set_inc ? ((years_q == YEAR_TOP) ? '0 : years_q + YEAR_ONE)
                             : ((years_q == '0) ? YEAR_TOP : years_q - YEAR_ONE);
  assign dim_mon_edit  = days_in_month(mon_edit, leap_cur);
  assign dim_year_edit = days_in_month(months_q, is_leap_year(year_edit));

  assign load_ok = (load_mon >= MON_ONE) && (load_mon <= MON_TOP) && (load_year <= YEAR_TOP) &&
                   (load_day >= DAY_ONE) &&
                   (load_day <= days_in_month(load_mon, is_leap_year(load_year)));

  always_comb begin
    days_d      = days_q;
    months_d    = months_q;
    years_d     = years_q;
    year_wrap_d = 1'b0;
    load_err_d  = 1'b0;
    if (load) begin
      if (load_ok) begin
        days_d   = load_day;
        months_d = load_mon;
        years_d  = load_year;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (mode_sel != MODE_RUN) begin
      if (set_inc ^ set_dec) begin
        case (mode_sel)
          MODE_SET_DAY: begin
            if (set_inc) days_d = (days_q == dim_cur) ? DAY_ONE : days_q + DAY_ONE;
            else         days_d = (days_q == DAY_ONE) ? dim_cur : days_q - DAY_ONE;
          end
          MODE_SET_MON: begin
            months_d = mon_edit;
            days_d   = (days_q > dim_mon_edit) ? dim_mon_edit : days_q;
          end
          MODE_SET_YEAR: begin
            years_d = year_edit;
            days_d  = (days_q > dim_year_edit) ? dim_year_edit : days_q;
          end
          default: ;
        endcase
      end
    end else if (day_tick) begin
      if (days_q != dim_cur) begin
        days_d = days_q + DAY_ONE;
      end else begin
        days_d = DAY_ONE;
        if (months_q != MON_TOP) begin
          months_d = months_q + MON_ONE;
        end else begin
          months_d = MON_ONE;
          if (years_q != YEAR_TOP) begin
            years_d = years_q + YEAR_ONE;
          end else begin
            years_d     = '0;
            year_wrap_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      days_q      <= DAY_ONE;
      months_q    <= MON_ONE;
      years_q     <= '0;
      dow_q       <= DOW_RESET;
      year_wrap_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      days_q      <= days_d;
      months_q    <= months_d;
      years_q     <= years_d;
      dow_q       <= sakamoto(days_q, months_q, years_q);
      year_wrap_q <= year_wrap_d;
      load_err_q  <= load_err_d;
    end
  end

  assign days      = days_q;
  assign months    = months_q;
  assign years     = years_q;
  assign dow       = dow_q;
  assign leap      = leap_cur;
  assign year_wrap = year_wrap_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_calendar_counter.sv
// Bench for calendar_counter: directed vector table, century-base corner cases and
// randomized traffic against a day-count calendar model, on a 2000-based and a 2100-based instance.
module tb_calendar_counter;

  logic       clk = 1'b0;
  logic       rst, day_tick, set_inc, set_dec, load;
  logic [1:0] mode;
  logic [4:0] load_day;
  logic [3:0] load_mon;
  logic [6:0] load_year;

  logic [4:0] days_a, days_b;
  logic [3:0] months_a, months_b;
  logic [6:0] years_a, years_b;
  logic [2:0] dow_a, dow_b;
  logic       leap_a, leap_b, yw_a, yw_b, le_a, le_b;

  always #5 clk = ~clk;

  calendar_counter dut_a (
    .clk_1Hz(clk), .rst(rst), .day_tick(day_tick), .mode(mode), .set_inc(set_inc), .set_dec(set_dec),
    .load(load), .load_day(load_day), .load_mon(load_mon), .load_year(load_year),
    .days(days_a), .months(months_a), .years(years_a), .dow(dow_a), .leap(leap_a),
    .year_wrap(yw_a), .load_err(le_a)
  );

  calendar_counter #(.YEAR_BASE(2100)) dut_b (
    .clk_1Hz(clk), .rst(rst), .day_tick(day_tick), .mode(mode), .set_inc(set_inc), .set_dec(set_dec),
    .load(load), .load_day(load_day), .load_mon(load_mon), .load_year(load_year),
    .days(days_b), .months(months_b), .years(years_b), .dow(dow_b), .leap(leap_b),
    .year_wrap(yw_b), .load_err(le_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, index 0 = base 2000, 1 = base 2100
  int md[2], mm[2], my[2], mdow[2], myw[2], mle[2];

  function automatic int m_leap(int yr);
    return ((yr % 4 == 0) && (yr % 100 != 0)) || (yr % 400 == 0) ? 1 : 0;
  endfunction

  function automatic int m_dim(int m, int yr);
    int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    return (m == 2) ? 28 + m_leap(yr) : tbl[m-1];
  endfunction

  // Days since 0000-12-31 in the proleptic Gregorian calendar; day 1 (0001-01-01) is a Monday.
  function automatic int m_dow(int d, int m, int yr);
    int n = 365 * (yr - 1) + (yr - 1) / 4 - (yr - 1) / 100 + (yr - 1) / 400 + d;
    for (int k = 1; k < m; k++) n += m_dim(k, yr);
    return n % 7;
  endfunction

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input int i, input int r, tk, mo, inc, dec, ld, ldd, ldm, ldy);
    int b    = (i == 0) ? 2000 : 2100;
    int nd   = m_dow(md[i], mm[i], b + my[i]);
    int step = (inc != 0) ? 1 : -1;
    int dim  = m_dim(mm[i], b + my[i]);
    myw[i] = 0;
    mle[i] = 0;
    if (r != 0) begin
      md[i] = 1; mm[i] = 1; my[i] = 0;
      nd = m_dow(1, 1, b);
    end else if (ld != 0) begin
      if (ldm >= 1 && ldm <= 12 && ldy <= 99 && ldd >= 1 && ldd <= m_dim(ldm, b + ldy)) begin
        md[i] = ldd; mm[i] = ldm; my[i] = ldy;
      end else begin
        mle[i] = 1;
      end
    end else if (mo != 0) begin
      if (inc != dec) begin
        case (mo)
          1: md[i] = (md[i] - 1 + step + dim) % dim + 1;
          2: begin
            mm[i] = (mm[i] - 1 + step + 12) % 12 + 1;
            md[i] = min2(md[i], m_dim(mm[i], b + my[i]));
          end
          default: begin
            my[i] = (my[i] + step + 100) % 100;
            md[i] = min2(md[i], m_dim(mm[i], b + my[i]));
          end
        endcase
      end
    end else if (tk != 0) begin
      md[i]++;
      if (md[i] > dim) begin
        md[i] = 1;
        mm[i]++;
        if (mm[i] > 12) begin
          mm[i] = 1;
          my[i]++;
          if (my[i] > 99) begin
            my[i] = 0;
            myw[i] = 1;
          end
        end
      end
    end
    mdow[i] = nd;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_models();
    check("a_days", int'(days_a), md[0]);     check("b_days", int'(days_b), md[1]);
    check("a_months", int'(months_a), mm[0]); check("b_months", int'(months_b), mm[1]);
    check("a_years", int'(years_a), my[0]);   check("b_years", int'(years_b), my[1]);
    check("a_dow", int'(dow_a), mdow[0]);     check("b_dow", int'(dow_b), mdow[1]);
    check("a_leap", int'(leap_a), m_leap(2000 + my[0]));
    check("b_leap", int'(leap_b), m_leap(2100 + my[1]));
    check("a_year_wrap", int'(yw_a), myw[0]); check("b_year_wrap", int'(yw_b), myw[1]);
    check("a_load_err", int'(le_a), mle[0]);  check("b_load_err", int'(le_b), mle[1]);
  endtask

  // One clock: drive inputs, step both models at the edge, compare 1 time unit later.
  task automatic cycle(input int r, tk, mo, inc, dec, ld, ldd, ldm, ldy);
    rst = (r != 0); day_tick = (tk != 0); mode = 2'(mo);
    set_inc = (inc != 0); set_dec = (dec != 0); load = (ld != 0);
    load_day = 5'(ldd); load_mon = 4'(ldm); load_year = 7'(ldy);
    @(posedge clk);
    model_step(0, r, tk, mo, inc, dec, ld, ldd, ldm, ldy);
    model_step(1, r, tk, mo, inc, dec, ld, ldd, ldm, ldy);
    #1;
    compare_models();
    $display("cyc r=%0d tk=%0d mo=%0d inc=%0d dec=%0d ld=%0d(%0d/%0d/%0d) -> A %0d/%0d/%0d dow=%0d B %0d/%0d/%0d dow=%0d",
             r, tk, mo, inc, dec, ld, ldd, ldm, ldy, days_a, months_a, years_a, dow_a,
             days_b, months_b, years_b, dow_b);
  endtask

  typedef struct {
    int r, tk, mo, inc, dec, ld, ldd, ldm, ldy;
    int ed, em, ey, el, eyw, ele, edow;
  } vec_t;

  vec_t vt[23];

  initial begin
    for (int i = 0; i < 2; i++) begin
      md[i] = 1; mm[i] = 1; my[i] = 0; mdow[i] = 0; myw[i] = 0; mle[i] = 0;
    end
    // r tk mo inc dec ld  ldd ldm ldy  |  days mon yr leap yw lerr dow (dow lags the date by one cycle)
    vt[0]  = '{1, 0, 0, 0, 0, 0,  0,  0,  0,   1,  1,  0, 1, 0, 0, 6};
    vt[1]  = '{0, 0, 0, 0, 0, 0,  0,  0,  0,   1,  1,  0, 1, 0, 0, 6};
    vt[2]  = '{0, 0, 0, 0, 0, 1, 28,  2,  0,  28,  2,  0, 1, 0, 0, 6};
    vt[3]  = '{0, 1, 0, 0, 0, 0,  0,  0,  0,  29,  2,  0, 1, 0, 0, 1};
    vt[4]  = '{0, 1, 0, 0, 0, 0,  0,  0,  0,   1,  3,  0, 1, 0, 0, 2};
    vt[5]  = '{0, 0, 0, 0, 0, 1, 28,  2,  1,  28,  2,  1, 0, 0, 0, 3};
    vt[6]  = '{0, 1, 0, 0, 0, 0,  0,  0,  0,   1,  3,  1, 0, 0, 0, 3};
    vt[7]  = '{0, 0, 0, 0, 0, 1, 31, 12, 99,  31, 12, 99, 0, 0, 0, 4};
    vt[8]  = '{0, 1, 0, 0, 0, 0,  0,  0,  0,   1,  1,  0, 1, 1, 0, 4};
    vt[9]  = '{0, 0, 0, 0, 0, 0,  0,  0,  0,   1,  1,  0, 1, 0, 0, 6};
    vt[10] = '{0, 0, 0, 0, 0, 1, 31,  1,  5,  31,  1,  5, 0, 0, 0, 6};
    vt[11] = '{0, 0, 2, 1, 0, 0,  0,  0,  0,  28,  2,  5, 0, 0, 0, 1};
    vt[12] = '{0, 0, 2, 1, 1, 0,  0,  0,  0,  28,  2,  5, 0, 0, 0, 1};
    vt[13] = '{0, 1, 2, 0, 0, 0,  0,  0,  0,  28,  2,  5, 0, 0, 0, 1};
    vt[14] = '{0, 0, 2, 0, 0, 1, 15,  6,  0,  15,  6,  0, 1, 0, 0, 1};
    vt[15] = '{0, 0, 3, 0, 1, 0,  0,  0,  0,  15,  6, 99, 0, 0, 0, 4};
    vt[16] = '{0, 0, 0, 0, 0, 1, 30,  2,  4,  15,  6, 99, 0, 0, 1, 1};
    vt[17] = '{0, 0, 0, 0, 0, 1, 29,  2,  4,  29,  2,  4, 1, 0, 0, 1};
    vt[18] = '{1, 1, 0, 0, 0, 1, 31, 12, 99,   1,  1,  0, 1, 0, 0, 6};
    vt[19] = '{0, 0, 1, 0, 1, 0,  0,  0,  0,  31,  1,  0, 1, 0, 0, 6};
    vt[20] = '{0, 0, 1, 1, 0, 0,  0,  0,  0,   1,  1,  0, 1, 0, 0, 1};
    vt[21] = '{0, 0, 0, 0, 0, 1, 10,  3, 99,  10,  3, 99, 0, 0, 0, 6};
    vt[22] = '{0, 0, 3, 1, 0, 0,  0,  0,  0,  10,  3,  0, 1, 0, 0, 2};

    for (int i = 0; i < 23; i++) begin
      cycle(vt[i].r, vt[i].tk, vt[i].mo, vt[i].inc, vt[i].dec, vt[i].ld, vt[i].ldd, vt[i].ldm, vt[i].ldy);
      check($sformatf("vec%0d_days", i), int'(days_a), vt[i].ed);
      check($sformatf("vec%0d_months", i), int'(months_a), vt[i].em);
      check($sformatf("vec%0d_years", i), int'(years_a), vt[i].ey);
      check($sformatf("vec%0d_leap", i), int'(leap_a), vt[i].el);
      check($sformatf("vec%0d_year_wrap", i), int'(yw_a), vt[i].eyw);
      check($sformatf("vec%0d_load_err", i), int'(le_a), vt[i].ele);
      check($sformatf("vec%0d_dow", i), int'(dow_a), vt[i].edow);
    end

    // Century rule: 2100 is not leap, 2000 is.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 28, 2, 0);
    check("century_b_leap", int'(leap_b), 0);
    check("century_a_leap", int'(leap_a), 1);
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("century_b_day", int'(days_b), 1);
    check("century_b_month", int'(months_b), 3);
    check("century_a_day", int'(days_a), 29);
    check("century_a_month", int'(months_a), 2);
    cycle(0, 0, 0, 0, 0, 1, 29, 2, 0);
    check("century_b_load_err", int'(le_b), 1);
    check("century_a_load_err", int'(le_a), 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("century_b_err_pulse", int'(le_b), 0);

    // Randomized traffic, compared against the model every cycle.
    for (int n = 0; n < 600; n++) begin
      int r, tk, mo, inc, dec, ld, ldd, ldm, ldy;
      r   = ($urandom_range(0, 59) == 0) ? 1 : 0;
      tk  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      mo  = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
      inc = int'($urandom_range(0, 1));
      dec = ($urandom_range(0, 2) == 0) ? 1 : 0;
      ld  = ($urandom_range(0, 11) == 0) ? 1 : 0;
      if ($urandom_range(0, 1) == 0) begin
        ldd = int'($urandom_range(26, 31));
        ldm = ($urandom_range(0, 1) == 0) ? 12 : 2;
        ldy = ($urandom_range(0, 1) == 0) ? 99 : int'($urandom_range(0, 8));
      end else begin
        ldd = int'($urandom_range(0, 31));
        ldm = int'($urandom_range(0, 15));
        ldy = int'($urandom_range(0, 127));
      end
      cycle(r, tk, mo, inc, dec, ld, ldd, ldm, ldy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
